wb_stage: RTL and testbench

Writeback stage of the five-stage in-order CPU. Accepts one retiring instruction per cycle from the memory stage over a valid/allowin handshake and holds it in a pipeline register. Aligns, sign/zero-extends or merges load data, then drives the register file write port (byte write mask, address, data). Also exports destination and data for decode-stage forwarding and the difftest trace.

---
 rtl/mycpu_pkg.sv | 38 +++
 rtl/wb_stage_if.sv | 30 +++
 rtl/load_align.sv | 66 ++++++
 rtl/wb_stage.sv | 103 ++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mycpu_pkg.sv
// Shared CPU package: load-op encoding, memory-to-writeback bus layout and
// the byte-mask constants used by the unaligned-load merges (LWL/LWR).
package mycpu_pkg;

    localparam int LD_W = 3;

    typedef enum logic [LD_W-1:0] {
        LD_NONE = 3'd0,
        LD_LW   = 3'd1,
        LD_LB   = 3'd2,
        LD_LBU  = 3'd3,
        LD_LH   = 3'd4,
        LD_LHU  = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } ld_op_e;

    // Payload carried from the memory stage into the writeback register.
    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        ld_op_e      ld_op;
        logic [1:0]  addr_lo;
        logic [31:0] result;
        logic [31:0] mem_rdata;
        logic [31:0] rt_old;
    } ms_to_ws_t;

    localparam int MS_TO_WS_BUS_W = $bits(ms_to_ws_t);

    localparam logic [3:0] MASK_FULL = 4'b1111;

    // Indexed by addr_lo; element 0 is the rightmost entry.
    localparam logic [3:0][3:0] LWL_MASK = {4'b1111, 4'b1110, 4'b1100, 4'b1000};
    localparam logic [3:0][3:0] LWR_MASK = {4'b0001, 4'b0011, 4'b0111, 4'b1111};

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to writeback-stage handshake and payload bus.
//   master : memory stage (drives valid + payload, sees ws_allowin)
//   slave  : writeback stage (consumes valid + payload, drives ws_allowin)
interface wb_stage_if;
    import mycpu_pkg::*;

    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    ld_op_e      ms_ld_op;
    logic [1:0]  ms_addr_lo;
    logic [31:0] ms_result;
    logic [31:0] ms_mem_rdata;
    logic [31:0] ms_rt_old;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_ld_op,
               ms_addr_lo, ms_result, ms_mem_rdata, ms_rt_old,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_ld_op,
               ms_addr_lo, ms_result, ms_mem_rdata, ms_rt_old,
        output ws_allowin
    );

endinterface

// File: rtl/load_align.sv
// Combinational load-data aligner. Selects/extends bytes and halfwords and
// builds the LWL/LWR merges with the old rt value. The returned data is
// always fully merged; mask reports which bytes the load architecturally
// touches.
//   ld_op, addr_lo, mem_rdata, rt_old, result -> data[31:0], mask[3:0]
module load_align
    import mycpu_pkg::*;
(
    input  ld_op_e      ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] rt_old,
    input  logic [31:0] result,
    output logic [31:0] data,
    output logic [3:0]  mask
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
    end

    // addr_lo[0] is irrelevant for halfwords; upstream guarantees alignment.
    assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        data = result;
        mask = MASK_FULL;
        case (ld_op)
            LD_LW:  data = mem_rdata;
            LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: data = {24'h0, byte_sel};
            LD_LH:  data = {{16{half_sel[15]}}, half_sel};
            LD_LHU: data = {16'h0, half_sel};
            LD_LWL: begin
                mask = LWL_MASK[addr_lo];
                case (addr_lo)
                    2'd0: data = {mem_rdata[7:0],  rt_old[23:0]};
                    2'd1: data = {mem_rdata[15:0], rt_old[15:0]};
                    2'd2: data = {mem_rdata[23:0], rt_old[7:0]};
                    default: data = mem_rdata;
                endcase
            end
            LD_LWR: begin
                mask = LWR_MASK[addr_lo];
                case (addr_lo)
                    2'd1: data = {rt_old[31:24], mem_rdata[31:8]};
                    2'd2: data = {rt_old[31:16], mem_rdata[31:16]};
                    2'd3: data = {rt_old[31:8],  mem_rdata[31:24]};
                    default: data = mem_rdata;
                endcase
            end
            default: data = result;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-entry pipeline register fed by the memory stage over
// valid/allowin, load alignment, register-file write port, decode-stage
// forwarding and difftest trace.
//   clk, resetn        : clock, async active-low reset
//   ms_bus (slave)     : memory-stage handshake + payload, ws_allowin back
//   wb_hold            : external stall (trace backpressure)
//   rf_we/waddr/wdata  : register-file write port (byte mask)
//   ws_fwd_*           : forwarding entry for decode
//   debug_wb_*         : trace mirror of the write port plus registered PC
module wb_stage
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    wb_stage_if.slave   ms_bus,
    input  logic        wb_hold,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ws_fwd_valid,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic                      ws_valid_q, ws_valid_d;
    logic [MS_TO_WS_BUS_W-1:0] ws_bus_q, ws_bus_d;
    ms_to_ws_t                 ms_pkt;
    ms_to_ws_t                 ws_pkt;
    logic                      ws_ready_go;
    logic                      ws_allowin;
    logic                      wr_live;
    logic [31:0]               final_data;
    logic [3:0]                final_mask;

    assign ws_ready_go       = !wb_hold;
    assign ws_allowin        = !ws_valid_q || ws_ready_go;
    assign ms_bus.ws_allowin = ws_allowin;

    assign ms_pkt = '{
        pc:        ms_bus.ms_pc,
        gr_we:     ms_bus.ms_gr_we,
        dest:      ms_bus.ms_dest,
        ld_op:     ms_bus.ms_ld_op,
        addr_lo:   ms_bus.ms_addr_lo,
        result:    ms_bus.ms_result,
        mem_rdata: ms_bus.ms_mem_rdata,
        rt_old:    ms_bus.ms_rt_old
    };
    assign ws_pkt = ms_to_ws_t'(ws_bus_q);

    always_comb begin
        ws_valid_d = ws_valid_q;
        ws_bus_d   = ws_bus_q;
        if (ws_allowin) begin
            ws_valid_d = ms_bus.ms_to_ws_valid;
            if (ms_bus.ms_to_ws_valid) begin
                ws_bus_d = ms_pkt;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_q <= 1'b0;
            ws_bus_q   <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            ws_bus_q   <= ws_bus_d;
        end
    end

    load_align u_load_align (
        .ld_op     (ws_pkt.ld_op),
        .addr_lo   (ws_pkt.addr_lo),
        .mem_rdata (ws_pkt.mem_rdata),
        .rt_old    (ws_pkt.rt_old),
        .result    (ws_pkt.result),
        .data      (final_data),
        .mask      (final_mask)
    );

    // $0 is never written or forwarded. Forwarding ignores hold so decode
    // still sees the pending value while writeback is stalled.
    assign wr_live = ws_valid_q && ws_pkt.gr_we && (ws_pkt.dest != 5'd0);

    assign rf_we    = (wr_live && ws_ready_go) ? final_mask : 4'b0000;
    assign rf_waddr = ws_pkt.dest;
    assign rf_wdata = final_data;

    assign ws_fwd_valid = wr_live;
    assign ws_fwd_dest  = ws_pkt.dest;
    assign ws_fwd_data  = final_data;

    assign debug_wb_pc       = ws_pkt.pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import mycpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_hold;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_stage_if ms_if ();

    wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_bus            (ms_if),
        .wb_hold           (wb_hold),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_valid      (ws_fwd_valid),
        .ws_fwd_dest       (ws_fwd_dest),
        .ws_fwd_data       (ws_fwd_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        ld_op_e      op;
        logic [1:0]  addr;
        logic [31:0] result;
        logic [31:0] mem;
        logic [31:0] rt;
        logic [3:0]  we;
        logic [31:0] data;
    } vec_t;

    exp_t exp_q[$];
    int   wr_cycles[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    vec_t vecs[16];

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle that presents a write must match the next expected write.
    exp_t e;
    always @(negedge clk) begin
        if (rf_we != 4'b0000) begin
            wr_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: pc %h waddr %0d we %b, expected no write",
                         debug_wb_pc, rf_waddr, rf_we);
            end else begin
                e = exp_q.pop_front();
                chk("wr_pc",     debug_wb_pc, e.pc);
                chk("wr_we",     32'(rf_we), 32'(e.we));
                chk("wr_waddr",  32'(rf_waddr), 32'(e.waddr));
                chk("wr_wdata",  rf_wdata, e.wdata);
                chk("fwd_valid", 32'(ws_fwd_valid), 32'd1);
                chk("fwd_dest",  32'(ws_fwd_dest), 32'(e.waddr));
                chk("fwd_data",  ws_fwd_data, e.wdata);
                chk("dbg_wen",   32'(debug_wb_rf_wen), 32'(e.we));
                chk("dbg_wnum",  32'(debug_wb_rf_wnum), 32'(e.waddr));
                chk("dbg_wdata", debug_wb_rf_wdata, e.wdata);
            end
        end
    end

    task automatic drive(input vec_t v);
        ms_if.ms_to_ws_valid = 1'b1;
        ms_if.ms_pc          = v.pc;
        ms_if.ms_gr_we       = v.gr_we;
        ms_if.ms_dest        = v.dest;
        ms_if.ms_ld_op       = v.op;
        ms_if.ms_addr_lo     = v.addr;
        ms_if.ms_result      = v.result;
        ms_if.ms_mem_rdata   = v.mem;
        ms_if.ms_rt_old      = v.rt;
    endtask

    task automatic expect_write(input vec_t v);
        exp_t x;
        x.pc    = v.pc;
        x.we    = v.we;
        x.waddr = v.dest;
        x.wdata = v.data;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   base;

        vecs[0]  = '{32'h1000, 1'b1, 5'd1,  LD_LB,   2'd2, 32'h0,        32'h80FF7F01, 32'h0,        4'hF, 32'hFFFFFFFF};
        vecs[1]  = '{32'h1004, 1'b1, 5'd2,  LD_LBU,  2'd3, 32'h0,        32'h80FF7F01, 32'h0,        4'hF, 32'h00000080};
        vecs[2]  = '{32'h1008, 1'b1, 5'd3,  LD_LWL,  2'd1, 32'h0,        32'hAABBCCDD, 32'h11223344, 4'hC, 32'hCCDD3344};
        vecs[3]  = '{32'h100C, 1'b1, 5'd4,  LD_LWR,  2'd2, 32'h0,        32'hAABBCCDD, 32'h11223344, 4'h3, 32'h1122AABB};
        vecs[4]  = '{32'h1010, 1'b1, 5'd5,  LD_LH,   2'd2, 32'h0,        32'h80FF7F01, 32'h0,        4'hF, 32'hFFFF80FF};
        vecs[5]  = '{32'h1014, 1'b1, 5'd6,  LD_LHU,  2'd0, 32'h0,        32'h80FF7F01, 32'h0,        4'hF, 32'h00007F01};
        vecs[6]  = '{32'h1018, 1'b1, 5'd7,  LD_LWL,  2'd0, 32'h0,        32'hAABBCCDD, 32'h11223344, 4'h8, 32'hDD223344};
        vecs[7]  = '{32'h101C, 1'b1, 5'd8,  LD_LWR,  2'd3, 32'h0,        32'hAABBCCDD, 32'h11223344, 4'h1, 32'h112233AA};
        vecs[8]  = '{32'h1020, 1'b1, 5'd9,  LD_LW,   2'd3, 32'h0,        32'h12345678, 32'h0,        4'hF, 32'h12345678};
        vecs[9]  = '{32'h1024, 1'b1, 5'd10, LD_NONE, 2'd1, 32'hDEADBEEF, 32'h0,        32'h0,        4'hF, 32'hDEADBEEF};
        vecs[10] = '{32'h1028, 1'b1, 5'd31, LD_LB,   2'd1, 32'h0,        32'h80FF7F01, 32'h0,        4'hF, 32'h0000007F};
        vecs[11] = '{32'h102C, 1'b1, 5'd12, LD_LWL,  2'd3, 32'h0,        32'hAABBCCDD, 32'h11223344, 4'hF, 32'hAABBCCDD};
        vecs[12] = '{32'h1030, 1'b1, 5'd13, LD_LWR,  2'd0, 32'h0,        32'hAABBCCDD, 32'h11223344, 4'hF, 32'hAABBCCDD};
        vecs[13] = '{32'h1034, 1'b1, 5'd14, LD_LWR,  2'd1, 32'h0,        32'hAABBCCDD, 32'h11223344, 4'h7, 32'h11AABBCC};
        vecs[14] = '{32'h1038, 1'b1, 5'd15, LD_LWL,  2'd2, 32'h0,        32'hAABBCCDD, 32'h11223344, 4'hE, 32'hBBCCDD44};
        vecs[15] = '{32'h103C, 1'b1, 5'd16, LD_LHU,  2'd2, 32'h0,        32'h80FF7F01, 32'h0,        4'hF, 32'h000080FF};

        // Idle inputs, then an async reset with no clock edge yet.
        resetn  = 1'b1;
        wb_hold = 1'b0;
        v = '{32'h0, 1'b0, 5'd0, LD_NONE, 2'd0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        drive(v);
        ms_if.ms_to_ws_valid = 1'b0;
        #1 resetn = 1'b0;
        #2;
        chk("rst_allowin",  32'(ms_if.ws_allowin), 32'd1);
        chk("rst_rf_we",    32'(rf_we), 32'd0);
        chk("rst_fwd",      32'(ws_fwd_valid), 32'd0);
        chk("rst_dbg_wen",  32'(debug_wb_rf_wen), 32'd0);
        chk("rst_dbg_pc",   debug_wb_pc, 32'd0);
        chk("rst_waddr",    32'(rf_waddr), 32'd0);
        chk("rst_wdata",    rf_wdata, 32'd0);
        #9 resetn = 1'b1;
        step();

        // Back-to-back streaming of every load flavour.
        base = wr_cycles.size();
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            expect_write(vecs[i]);
            step();
        end
        ms_if.ms_to_ws_valid = 1'b0;
        step();
        step();
        chk("stream_writes", 32'(wr_cycles.size() - base), 32'd16);
        if (wr_cycles.size() >= base + 16)
            chk("stream_span", 32'(wr_cycles[base + 15] - wr_cycles[base]), 32'd15);

        // Writes to $0 and non-writing instructions are suppressed.
        v = '{32'h2000, 1'b1, 5'd0, LD_NONE, 2'd0, 32'h1234, 32'h0, 32'h0, 4'h0, 32'h0};
        drive(v);
        step();
        chk("r0_rf_we",   32'(rf_we), 32'd0);
        chk("r0_fwd",     32'(ws_fwd_valid), 32'd0);
        chk("r0_dbg_wen", 32'(debug_wb_rf_wen), 32'd0);
        v = '{32'h2004, 1'b0, 5'd9, LD_NONE, 2'd0, 32'h5678, 32'h0, 32'h0, 4'h0, 32'h0};
        drive(v);
        step();
        chk("nowe_rf_we", 32'(rf_we), 32'd0);
        chk("nowe_fwd",   32'(ws_fwd_valid), 32'd0);
        chk("nowe_pc",    debug_wb_pc, 32'h2004);
        ms_if.ms_to_ws_valid = 1'b0;
        step();

        // Hold for three cycles with the next instruction waiting.
        v = '{32'h100, 1'b1, 5'd5, LD_NONE, 2'd0, 32'hCAFE, 32'h0, 32'h0, 4'hF, 32'hCAFE};
        drive(v);
        expect_write(v);
        step();
        wb_hold = 1'b1;
        v = '{32'h104, 1'b1, 5'd6, LD_NONE, 2'd0, 32'hBEEF, 32'h0, 32'h0, 4'hF, 32'hBEEF};
        drive(v);
        expect_write(v);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_allowin", 32'(ms_if.ws_allowin), 32'd0);
            chk("hold_rf_we",   32'(rf_we), 32'd0);
            chk("hold_fwd",     32'(ws_fwd_valid), 32'd1);
            chk("hold_pc",      debug_wb_pc, 32'h100);
            step();
        end
        wb_hold = 1'b0;
        #1;
        chk("rel_rf_we",   32'(rf_we), 32'hF);
        chk("rel_waddr",   32'(rf_waddr), 32'd5);
        chk("rel_allowin", 32'(ms_if.ws_allowin), 32'd1);
        step();
        ms_if.ms_to_ws_valid = 1'b0;
        chk("next_pc",    debug_wb_pc, 32'h104);
        chk("next_waddr", 32'(rf_waddr), 32'd6);
        step();

        // Async reset while an instruction is valid: dropped, no write.
        v = '{32'h200, 1'b1, 5'd7, LD_NONE, 2'd0, 32'h77, 32'h0, 32'h0, 4'h0, 32'h0};
        drive(v);
        step();
        ms_if.ms_to_ws_valid = 1'b0;
        chk("pre_rst_fwd", 32'(ws_fwd_valid), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
        chk("mid_rst_fwd",   32'(ws_fwd_valid), 32'd0);
        chk("mid_rst_pc",    debug_wb_pc, 32'd0);
        step();
        #2 resetn = 1'b1;
        #1;
        chk("post_rst_allowin", 32'(ms_if.ws_allowin), 32'd1);
        chk("post_rst_rf_we",   32'(rf_we), 32'd0);
        step();

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
